// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared state encodings, opcodes, ALU control and trap causes for mips_multicycle
package mips_mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWB  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_EXEC   = 4'd6;
  localparam state_t S_ALUWB  = 4'd7;
  localparam state_t S_BRANCH = 4'd8;
  localparam state_t S_ADDIEX = 4'd9;
  localparam state_t S_ADDIWB = 4'd10;
  localparam state_t S_JUMP   = 4'd11;
  localparam state_t S_TRAP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_t;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_MEMTO   = 2'b10;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic alu_ctrl_t alu_ctrl(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Wrap-around arithmetic; slt compares as signed two's complement.
  function automatic logic [31:0] alu_op(input alu_ctrl_t c, input logic [31:0] x,
                                         input logic [31:0] y);
    case (c)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return {31'd0, ($signed(x) < $signed(y))};
      default: return x + y;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// rtl/mips_mc_regfile.sv - 32x32 register file, two async read ports, one clocked write port, $0 hardwired to zero
module mips_mc_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  // Writes to $0 are dropped; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - unified-memory multicycle MIPS core; optional bne support under MIPS_MC_BNE_EN
module mips_multicycle
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam logic [15:0] WCNT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state, state_nx, dec_nx;
  logic [31:0] ir, a, b, aluout, mdr, target;
  logic [15:0] wcnt;
  logic        is_mem, timeout, br_inv;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, rf_rd1, rf_rd2;

  wire [5:0]  op       = ir[31:26];
  wire [4:0]  rs       = ir[25:21];
  wire [4:0]  rt       = ir[20:16];
  wire [4:0]  rd       = ir[15:11];
  wire [5:0]  funct    = ir[5:0];
  wire [31:0] imm_sext = {{16{ir[15]}}, ir[15:0]};

  assign is_mem    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout   = is_mem && !mem_ready && (wcnt == WCNT_LAST);
  assign mem_req   = reset && is_mem;
  assign mem_we    = (state == S_MEMWR);
  assign mem_addr  = (state == S_FETCH) ? pc : aluout;
  assign mem_wdata = b;

`ifdef MIPS_MC_BNE_EN
  assign br_inv = (op == OP_BNE);
`else
  assign br_inv = 1'b0;
`endif

  mips_mc_regfile u_rf (
    .clk (clk),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  // Opcode dispatch out of DECODE; anything unrecognised lands in TRAP.
  always_comb begin
    dec_nx = S_TRAP;
    case (op)
      OP_RTYPE:     if (funct_ok(funct)) dec_nx = S_EXEC;
      OP_LW, OP_SW: dec_nx = S_MEMADR;
      OP_BEQ:       dec_nx = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
      OP_BNE:       dec_nx = S_BRANCH;
`endif
      OP_ADDI:      dec_nx = S_ADDIEX;
      OP_J:         dec_nx = S_JUMP;
      default:      dec_nx = S_TRAP;
    endcase
  end

  // Next-state logic; a memory timeout overrides any other transition.
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: state_nx = dec_nx;
      S_MEMADR: state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
      S_EXEC:   state_nx = S_ALUWB;
      S_ADDIEX: state_nx = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_TRAP;
    endcase
    if (timeout) state_nx = S_TRAP;
  end

  // Register write-back select; suppressed while reset is asserted.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = rt;
    rf_wd = aluout;
    case (state)
      S_MEMWB:  begin rf_we = reset; rf_wd = mdr; end
      S_ALUWB:  begin rf_we = reset; rf_wa = rd; end
      S_ADDIWB: rf_we = reset;
      default:  rf_we = 1'b0;
    endcase
  end

  // State, wait counter and sticky trap status.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_FETCH;
      wcnt       <= '0;
      trap       <= 1'b0;
      trap_cause <= TC_NONE;
    end else begin
      state <= state_nx;
      if (state_nx != state) wcnt <= '0;
      else if (is_mem && !mem_ready) wcnt <= wcnt + 16'd1;
      if ((state != S_TRAP) && (state_nx == S_TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= timeout ? TC_MEMTO : TC_ILLEGAL;
      end
    end
  end

  // Datapath registers: pc, instruction, operands, ALU result, memory data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        S_DECODE: begin
          a      <= rf_rd1;
          b      <= rf_rd2;
          target <= pc + (imm_sext << 2);
        end
        S_MEMADR, S_ADDIEX: aluout <= a + imm_sext;
        S_EXEC:   aluout <= alu_op(alu_ctrl(funct), a, b);
        S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        S_BRANCH: if ((a == b) ^ br_inv) pc <= target;
        S_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - directed self-checking bench for mips_multicycle with a store scoreboard
module tb_mips_multicycle;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [1:0]  trap_cause;

  logic [31:0] mem [256];
  int          delay;
  int          wcnt_tb;
  logic        stall_en;
  logic [31:0] stall_addr;
  logic        stab_en;
  logic        prev_wait, prev_we;
  logic [31:0] prev_addr, prev_wdata;
  st_t         sb_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  mips_multicycle #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .pc         (pc),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  // Memory responder: ready after 'delay' wait cycles unless the address is stalled.
  always_comb begin
    mem_ready = mem_req && (wcnt_tb >= delay) && !(stall_en && (mem_addr == stall_addr));
    mem_rdata = mem[mem_addr[9:2]];
  end

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt_tb <= wcnt_tb + 1;
    else wcnt_tb <= 0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'b000010, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, run bus monitors, retire completed stores.
  task automatic cyc();
    st_t e;
    @(negedge clk);
    if (stab_en && prev_wait) begin
      check("hold_req", {31'd0, mem_req}, 32'd1);
      check("hold_addr", mem_addr, prev_addr);
      check("hold_we", {31'd0, mem_we}, {31'd0, prev_we});
      check("hold_wdata", mem_wdata, prev_wdata);
    end
    if (stab_en && mem_req && mem_we && !mem_ready && (sb_q.size() > 0)) begin
      check("wait_waddr", mem_addr, sb_q[0].addr);
      check("wait_wdata", mem_wdata, sb_q[0].data);
    end
    prev_wait  = mem_req && !mem_ready;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
    if (mem_req && mem_we && mem_ready) begin
      n_cmp++;
      assert (sb_q.size() > 0) else begin
        n_bad++;
        $error("FAIL unexpected_store observed addr=%h data=%h expected no store", mem_addr, mem_wdata);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("store_addr", mem_addr, e.addr);
        check("store_data", mem_wdata, e.data);
      end
      mem[mem_addr[9:2]] = mem_wdata;
    end
  endtask

  task automatic clk_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic enter_reset();
    reset = 1'b0;
    sb_q.delete();
    prev_wait = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; (i < bound) && (sb_q.size() != 0); i++) cyc();
    check(tag, sb_q.size(), 32'd0);
  endtask

  initial begin
    logic found;
    logic saw;
    int   waits;

    delay = 0; stall_en = 1'b0; stall_addr = 32'd0; stab_en = 1'b0;
    enter_reset();
    clk_n(2);
    check("rst_pc", pc, 32'h0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_cause", {30'd0, trap_cause}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);

    // addi/addi/add, jump to 0x100, then sw/lw/sw through a slow memory and a beq loop
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2]  = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
    mem[3]  = enc_j(26'h40);
    mem[64] = enc_i(6'h2b, 5'd0, 5'd3, 16'h0010);
    mem[65] = enc_i(6'h23, 5'd0, 5'd4, 16'h0010);
    mem[66] = enc_i(6'h2b, 5'd0, 5'd4, 16'h0014);
    mem[67] = enc_i(6'h04, 5'd1, 5'd1, 16'hffff);
    sb_q.push_back('{32'h10, 32'd12});
    sb_q.push_back('{32'h14, 32'd12});
    reset = 1'b1;
    #1;
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    clk_n(11);
    check("aluwb_no_req", {31'd0, mem_req}, 32'd0);
    clk_n(1);
    check("pc_after_12", pc, 32'd12);
    check("fetch4_req", {31'd0, mem_req}, 32'd1);
    check("fetch4_addr", mem_addr, 32'd12);
    clk_n(3);
    check("jump_pc", pc, 32'h100);
    delay = 3; stab_en = 1'b1;
    drain("drain_swlw", 200);
    stab_en = 1'b0; delay = 0;
    found = 1'b0;
    for (int i = 0; (i < 50) && !found; i++) begin
      if (mem_req && mem_ready && (mem_addr == 32'h10c)) found = 1'b1;
      else cyc();
    end
    check("beq_seen", {31'd0, found}, 32'd1);
    clk_n(1);
    check("beq_dec_pc", pc, 32'h110);
    check("beq_dec_req", {31'd0, mem_req}, 32'd0);
    clk_n(2);
    check("beq_loop_req", {31'd0, mem_req}, 32'd1);
    check("beq_loop_addr", mem_addr, 32'h10c);
    check("beq_loop_pc", pc, 32'h10c);

    // ALU mix: sub wrap, and, or, signed slt both ways, $0 write discard, untaken beq
    enter_reset();
    mem[0]  = enc_i(6'h08, 5'd0, 5'd6, 16'hfffd);
    mem[1]  = enc_r(6'h22, 5'd1, 5'd2, 5'd7);
    mem[2]  = enc_r(6'h24, 5'd1, 5'd2, 5'd8);
    mem[3]  = enc_r(6'h25, 5'd1, 5'd2, 5'd9);
    mem[4]  = enc_r(6'h2a, 5'd6, 5'd1, 5'd10);
    mem[5]  = enc_r(6'h2a, 5'd1, 5'd6, 5'd11);
    mem[6]  = enc_r(6'h20, 5'd1, 5'd2, 5'd0);
    mem[7]  = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
    mem[8]  = enc_i(6'h2b, 5'd0, 5'd7, 16'h0080);
    mem[9]  = enc_i(6'h2b, 5'd0, 5'd8, 16'h0084);
    mem[10] = enc_i(6'h2b, 5'd0, 5'd9, 16'h0088);
    mem[11] = enc_i(6'h2b, 5'd0, 5'd10, 16'h008c);
    mem[12] = enc_i(6'h2b, 5'd0, 5'd11, 16'h0090);
    mem[13] = enc_i(6'h2b, 5'd0, 5'd0, 16'h0094);
    mem[14] = enc_i(6'h04, 5'd0, 5'd0, 16'hffff);
    sb_q.push_back('{32'h80, 32'hffff_fffe});
    sb_q.push_back('{32'h84, 32'd5});
    sb_q.push_back('{32'h88, 32'd7});
    sb_q.push_back('{32'h8c, 32'd1});
    sb_q.push_back('{32'h90, 32'd0});
    sb_q.push_back('{32'h94, 32'd0});
    clk_n(2);
    reset = 1'b1;
    drain("drain_alu", 300);

    // Illegal opcode traps one cycle after DECODE and stays quiet
    enter_reset();
    mem[0] = 32'hfc00_0000;
    clk_n(2);
    reset = 1'b1;
    clk_n(1);
    check("ill_pre_trap", {31'd0, trap}, 32'd0);
    clk_n(1);
    check("ill_trap", {31'd0, trap}, 32'd1);
    check("ill_cause", {30'd0, trap_cause}, 32'd1);
    check("ill_req", {31'd0, mem_req}, 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (mem_req) saw = 1'b1;
    end
    check("ill_req_quiet", {31'd0, saw}, 32'd0);
    check("ill_pc_frozen", pc, 32'd4);

    // lw with the data port never ready -> timeout after 16 wait cycles
    enter_reset();
    mem[0] = enc_i(6'h23, 5'd0, 5'd5, 16'h0010);
    stall_en = 1'b1; stall_addr = 32'h10;
    clk_n(2);
    reset = 1'b1;
    clk_n(3);
    waits = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem_req && !mem_ready && (mem_addr == 32'h10)) waits++;
      if (i < 15) cyc();
    end
    check("to_waits", waits, 32'd16);
    check("to_pre_trap", {31'd0, trap}, 32'd0);
    clk_n(1);
    check("to_trap", {31'd0, trap}, 32'd1);
    check("to_cause", {30'd0, trap_cause}, 32'd2);
    check("to_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;
    clk_n(1);
    check("rst2_pc", pc, 32'h0);
    check("rst2_trap", {31'd0, trap}, 32'd0);
    check("rst2_cause", {30'd0, trap_cause}, 32'd0);
    check("rst2_req", {31'd0, mem_req}, 32'd0);
    stall_en = 1'b0;

    // bne $1,$2,+2 with $1=5, $2=7 (register contents survive reset)
    enter_reset();
    mem[0] = enc_i(6'h05, 5'd1, 5'd2, 16'd2);
    clk_n(2);
    reset = 1'b1;
    clk_n(2);
`ifdef MIPS_MC_BNE_EN
    check("bne_no_trap", {31'd0, trap}, 32'd0);
    clk_n(1);
    check("bne_pc", pc, 32'd12);
    check("bne_fetch_addr", mem_addr, 32'd12);
`else
    check("bne_trap", {31'd0, trap}, 32'd1);
    check("bne_cause", {30'd0, trap_cause}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
